// File: rtl/jtag_dr_link.sv
// JTAG user data-register responder: captures a design snapshot with a status
// header for readback and accepts a keyed control word on UPDATE-DR.
module jtag_dr_link #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             tdi,
  output logic             tdo,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] ctrl_out,
  output logic             ctrl_valid,
  output logic             err_len,
  output logic             err_key
);

  localparam int L  = WIDTH + 8;
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] CNT_LEN = CW'(L);
  localparam logic [CW-1:0] CNT_MAX = CW'(L + 1);

  typedef enum logic [1:0] {IDLE, CAPTURED, SHIFTING} state_t;

  state_t        state;
  logic [L-1:0]  sr;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    seq;

  assign tdo = sr[0];

  // Handshake: controls are qualified by sel and sampled on the rising edge;
  // capture outranks shift, which outranks update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      seq        <= '0;
      ctrl_out   <= CTRL_RESET;
      ctrl_valid <= 1'b0;
      err_len    <= 1'b0;
      err_key    <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      if (sel) begin
        if (capture) begin
          // Header reports the flags before they are cleared by this read.
          sr      <= {data_in, seq, err_key, err_len, 4'hA};
          bit_cnt <= '0;
          seq     <= seq + 2'd1;
          err_len <= 1'b0;
          err_key <= 1'b0;
          state   <= CAPTURED;
        end else if (shift) begin
          sr <= {tdi, sr[L-1:1]};
          // Saturating one past L keeps over-length frames distinguishable.
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
          if (state != IDLE) state <= SHIFTING;
        end else if (update) begin
          state <= IDLE;
          if (bit_cnt != CNT_LEN) begin
            err_len <= 1'b1;
          end else if (sr[3:0] != 4'h5) begin
            err_key <= 1'b1;
          end else begin
            ctrl_out   <= sr[L-1:8];
            ctrl_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dr_link.sv
// Directed bench for jtag_dr_link with WIDTH=8 (16-bit data register).
module tb_jtag_dr_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b1;
  logic       capture = 1'b0;
  logic       shift = 1'b0;
  logic       update = 1'b0;
  logic       tdi = 1'b0;
  logic       tdo;
  logic [7:0] data_in = 8'h00;
  logic [7:0] ctrl_out;
  logic       ctrl_valid;
  logic       err_len;
  logic       err_key;

  int n_cmp = 0;
  int n_err = 0;

  jtag_dr_link #(.WIDTH(8), .CTRL_RESET(8'h00)) dut (
    .clk(clk), .reset(reset), .sel(sel), .capture(capture), .shift(shift),
    .update(update), .tdi(tdi), .tdo(tdo), .data_in(data_in),
    .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .err_len(err_len),
    .err_key(err_key)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_capture(input logic [7:0] d);
    data_in = d;
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // Shift n bits of tdi_w LSB-first, checking tdo against exp_w for the first nchk bits.
  task automatic shift_frame(input string name, input int n, input logic [31:0] tdi_w,
                             input logic [15:0] exp_w, input int nchk);
    logic [15:0] e;
    e = exp_w;
    for (int i = 0; i < n; i++) begin
      if (i < nchk) begin
        n_cmp++;
        if (tdo !== e[i % 16]) begin
          n_err++;
          $display("FAIL %s tdo bit %0d: got %b expected %b", name, i, tdo, e[i % 16]);
        end
      end
      tdi   = tdi_w[i % 32];
      shift = 1'b1;
      tick();
    end
    shift = 1'b0;
    tdi   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({tdo, ctrl_out, ctrl_valid, err_len, err_key} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got tdo=%b ctrl=%h v=%b el=%b ek=%b expected all zero",
               tdo, ctrl_out, ctrl_valid, err_len, err_key);
    end
    do_capture(8'h5C);
    shift_frame("readback_5c", 16, 32'h0, 16'h5C0A, 16);
  endtask

  task automatic test_accept();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_capture(8'h00);
    shift_frame("accept_hdr", 16, 32'h3C05, 16'h000A, 16);
    n_cmp++;
    if (ctrl_out !== 8'h00) begin
      n_err++;
      $display("FAIL ctrl_before_update: got %h expected 00", ctrl_out);
    end
    do_update();
    n_cmp++;
    if ({ctrl_out, ctrl_valid, err_len, err_key} !== {8'h3C, 3'b100}) begin
      n_err++;
      $display("FAIL accept: got ctrl=%h v=%b el=%b ek=%b expected ctrl=3c v=1 el=0 ek=0",
               ctrl_out, ctrl_valid, err_len, err_key);
    end
    tick();
    n_cmp++;
    if ({ctrl_out, ctrl_valid} !== {8'h3C, 1'b0}) begin
      n_err++;
      $display("FAIL pulse_width: got ctrl=%h v=%b expected ctrl=3c v=0", ctrl_out, ctrl_valid);
    end
  endtask

  task automatic test_short_frame();
    do_capture(8'h11);
    shift_frame("short_hdr", 15, 32'h0, 16'h114A, 15);
    do_update();
    n_cmp++;
    if ({ctrl_out, ctrl_valid, err_len, err_key} !== {8'h3C, 3'b010}) begin
      n_err++;
      $display("FAIL short_frame: got ctrl=%h v=%b el=%b ek=%b expected ctrl=3c v=0 el=1 ek=0",
               ctrl_out, ctrl_valid, err_len, err_key);
    end
  endtask

  task automatic test_key_and_overlength();
    do_capture(8'hC3);
    n_cmp++;
    if ({err_len, err_key} !== 2'b00) begin
      n_err++;
      $display("FAIL clear_on_read: got el=%b ek=%b expected 0 0", err_len, err_key);
    end
    shift_frame("err_hdr", 16, 32'h7704, 16'hC39A, 16);
    do_update();
    n_cmp++;
    if ({ctrl_out, ctrl_valid, err_len, err_key} !== {8'h3C, 3'b001}) begin
      n_err++;
      $display("FAIL bad_key: got ctrl=%h v=%b el=%b ek=%b expected ctrl=3c v=0 el=0 ek=1",
               ctrl_out, ctrl_valid, err_len, err_key);
    end
    // Last 16 bits form a well-keyed 0x7F05 frame; only the count must reject it.
    shift_frame("overlength", 20, 32'h0007F050, 16'h0000, 0);
    do_update();
    n_cmp++;
    if ({ctrl_out, ctrl_valid, err_len, err_key} !== {8'h3C, 3'b011}) begin
      n_err++;
      $display("FAIL overlength: got ctrl=%h v=%b el=%b ek=%b expected ctrl=3c v=0 el=1 ek=1",
               ctrl_out, ctrl_valid, err_len, err_key);
    end
    do_capture(8'h00);
    shift_frame("both_flags_hdr", 8, 32'h0, 16'h00FA, 8);
  endtask

  task automatic test_reset_mid_shift();
    shift_frame("pre_reset", 5, 32'h1F, 16'h0000, 0);
    reset = 1'b1;
    shift = 1'b1;
    tick();
    reset = 1'b0;
    shift = 1'b0;
    n_cmp++;
    if ({tdo, ctrl_out, ctrl_valid, err_len, err_key} !== 12'h000) begin
      n_err++;
      $display("FAIL mid_shift_reset: got tdo=%b ctrl=%h v=%b el=%b ek=%b expected all zero",
               tdo, ctrl_out, ctrl_valid, err_len, err_key);
    end
    do_capture(8'hA5);
    shift_frame("post_reset_hdr", 16, 32'h1105, 16'hA50A, 16);
    do_update();
    n_cmp++;
    if ({ctrl_out, ctrl_valid} !== {8'h11, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_accept: got ctrl=%h v=%b expected ctrl=11 v=1", ctrl_out, ctrl_valid);
    end
  endtask

  task automatic test_sel_and_wrap();
    logic [7:0] hdr [5];
    tick();
    sel     = 1'b0;
    data_in = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      capture = (i % 2 == 0);
      shift   = (i % 3 != 2);
      update  = (i % 2 == 1);
      tdi     = 1'b0;
      tick();
      n_cmp++;
      if ({tdo, ctrl_out, ctrl_valid} !== {1'b1, 8'h11, 1'b0}) begin
        n_err++;
        $display("FAIL sel_low cycle %0d: got tdo=%b ctrl=%h v=%b expected tdo=1 ctrl=11 v=0",
                 i, tdo, ctrl_out, ctrl_valid);
      end
    end
    capture = 1'b0;
    shift   = 1'b0;
    update  = 1'b0;
    sel     = 1'b1;
    do_capture(8'h00);
    shift_frame("seq_held_hdr", 8, 32'h0, 16'h004A, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hdr[0] = 8'h0A; hdr[1] = 8'h4A; hdr[2] = 8'h8A; hdr[3] = 8'hCA; hdr[4] = 8'h0A;
    for (int k = 0; k < 5; k++) begin
      do_capture(8'h00);
      shift_frame($sformatf("wrap_hdr%0d", k), 8, 32'h0, {8'h00, hdr[k]}, 8);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_short_frame();
    test_key_and_overlength();
    test_reset_mid_shift();
    test_sel_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_dr_link.md
Name: jtag_dr_link

Overview:
- JTAG user data-register responder for the readback/clock-control designs.
- Sits behind the BSCANE2 user-register decode and runs on the TCK-derived global clock.
- On CAPTURE-DR it snapshots a design value plus a status header, then shifts it out on TDO LSB-first (design-to-host).
- On UPDATE-DR it validates the word shifted in on TDI and drives it to the design as a control word (host-to-design).

Parameters:
- WIDTH, 8, width of the design snapshot and of the control word.
- CTRL_RESET, 0, reset value of ctrl_out.
- Derived, not overridable: L = WIDTH+8, the data-register length (8-bit header plus payload).

Ports:
- clk  in  1  TCK-derived global clock; all BSCANE2 controls are sampled on its rising edge.
- reset  in  1  synchronous, active-high.
- sel  in  1  user register selected.
- capture  in  1  CAPTURE-DR state.
- shift  in  1  SHIFT-DR state.
- update  in  1  UPDATE-DR state.
- tdi  in  1  serial data from host.
- tdo  out  1  serial data to host; equals sr[0] (register output, no combinational path from inputs).
- data_in  in  WIDTH  design value to read back (e.g. LED counter).
- ctrl_out  out  WIDTH  last accepted control word.
- ctrl_valid  out  1  one-cycle pulse when ctrl_out is loaded.
- err_len  out  1  sticky framing-length error.
- err_key  out  1  sticky key error.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high.
- Reset values:
  - sr = 0, hence tdo = 0.
  - bit_cnt = 0, seq = 0, state = IDLE.
  - ctrl_out = CTRL_RESET, ctrl_valid = 0, err_len = 0, err_key = 0.
- Reset mid-shift aborts the frame silently; no error is flagged.
- sel = 0: capture, shift and update are ignored and all state is held.
- Priority when more than one control is high (illegal, but defined): capture > shift > update.
- State machine: IDLE, CAPTURED, SHIFTING.
  - Any state + capture → CAPTURED.
  - CAPTURED or SHIFTING + shift → SHIFTING.
  - Any state + update → IDLE.
- Capture:
  - sr <= {data_in, seq[1:0], err_key, err_len, 4'hA}.
  - bit_cnt <= 0; seq <= seq+1, wrapping 3→0.
  - err_len and err_key clear in the same cycle (clear-on-read: the reported values are the pre-clear values).
  - tdo shows the new sr[0] on the next cycle.
- Shift:
  - sr <= {tdi, sr[L-1:1]}.
  - bit_cnt increments and saturates at L+1, so over-length frames are detectable.
- Update, evaluated on the sr/bit_cnt values present in that cycle:
  - Accept when bit_cnt == L and sr[3:0] == 4'h5. Then ctrl_out <= sr[L-1:8] and ctrl_valid = 1 for exactly the next cycle.
  - bit_cnt != L: err_len <= 1; ctrl_out unchanged; no pulse.
  - bit_cnt == L but key mismatch: err_key <= 1; ctrl_out unchanged.
  - Update with no preceding shifts (bit_cnt = 0) sets err_len.
  - sr[7:4] of the incoming frame are ignored.
- Capture-only frames (capture followed by update, no shifts) are therefore flagged err_len. The host must do a full L-bit read/write exchange, or tolerate the flag.
- Latency: ctrl_out and ctrl_valid are registered, 1 cycle after update is sampled.
- Every bit shifted out is replaced by a tdi bit, so a readback and a control write happen in the same L-bit scan.

Test Plan (WIDTH=8, L=16):
1. Reset, then capture with data_in=0x5C → sr=0x5C0A. The next 16 shifts give tdo LSB-first 0,1,0,1,0,0,0,0,0,0,1,1,1,0,1,0.
2. Capture, then 16 shifts with tdi = 0x3C05 LSB-first, then update → ctrl_out=0x3C with ctrl_valid high for exactly 1 cycle; err flags 0.
3. Capture, 15 shifts, update → err_len=1, ctrl_out holds 0x3C, no pulse. The next capture (seq=2) loads header 0x9A (seq=2 in bits[7:6], err_len=1 in bit 4, magic 0xA), and err_len reads 0 the cycle after that capture.
4. Capture, 16 shifts with tdi = 0x7704 (key 4), update → err_key=1, ctrl_out unchanged. 20 shifts then update → err_len=1, with bit_cnt saturated at 17.
5. Assert reset mid-shift after 5 bits → all outputs return to reset values on the next edge. A following clean capture reports seq=0 and header 0x0A.
6. sel=0 with capture/shift/update toggling → sr, seq and ctrl_out unchanged. Then five consecutive captures → the reported seq sequence is 0,1,2,3,0 (wrap).
